// File: rtl/hex_display_bank.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_bank
// Function : registered active-low 7-segment driver for a bank of hex digits,
//            with leading-zero blanking, masked blink and optional scan
//            outputs (enabled by defining HEX_BANK_SCAN_EN).
// Revision : 1.0 - initial release
// ============================================================================
module hex_display_bank #(
  parameter int DIGITS    = 6,
  parameter int BLINK_DIV = 25000000,
  parameter int SCAN_DIV  = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     blink_mask,
`ifdef HEX_BANK_SCAN_EN
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
`endif
  output logic [7*DIGITS-1:0]   hex
);

  localparam int BLINK_W = $clog2(BLINK_DIV);

  logic [4*DIGITS-1:0] value_q;
  logic [BLINK_W-1:0]  blink_cnt;
  logic                phase;
  logic [7*DIGITS-1:0] hex_next;
  logic                zero_run;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0: code = 7'h40;
      4'h1: code = 7'h79;
      4'h2: code = 7'h24;
      4'h3: code = 7'h30;
      4'h4: code = 7'h19;
      4'h5: code = 7'h12;
      4'h6: code = 7'h02;
      4'h7: code = 7'h78;
      4'h8: code = 7'h00;
      4'h9: code = 7'h10;
      4'hA: code = 7'h08;
      4'hB: code = 7'h03;
      4'hC: code = 7'h46;
      4'hD: code = 7'h21;
      4'hE: code = 7'h06;
      default: code = 7'h0E;
    endcase
    return code;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q   <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
      hex       <= '1;
    end else begin
      if (load) begin
        value_q <= value;
      end
      if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
      hex <= hex_next;
    end
  end

  // Walk from the most significant digit down; zero_run stays set while every
  // nibble seen so far is zero, which is exactly the leading-zero condition.
  always_comb begin
    hex_next = '1;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (value_q[4*i +: 4] == 4'h0);
      if ((blank_lz && (i != 0) && zero_run) || (phase && blink_mask[i])) begin
        hex_next[7*i +: 7] = 7'h7F;
      end else begin
        hex_next[7*i +: 7] = decode(value_q[4*i +: 4]);
      end
    end
  end

`ifdef HEX_BANK_SCAN_EN
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [SCAN_W-1:0] scan_cnt;
  logic [IDX_W-1:0]  scan_idx;

  // seg takes the same next-state field that hex is loading, so the scanned
  // digit and the static field always agree on a given edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      seg      <= 7'h7F;
      an       <= '1;
    end else begin
      if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      an  <= ~(DIGITS'(1) << scan_idx);
      seg <= hex_next[7*scan_idx +: 7];
    end
  end
`else
  if (SCAN_DIV < 1) begin : g_scan_div_range
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hex_display_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_display_bank
// Function : directed self-checking bench for hex_display_bank (6-digit and
//            1-digit instances; scan checks when HEX_BANK_SCAN_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_display_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_load, a_blz;
  logic [23:0] a_value;
  logic [5:0]  a_mask;
  logic [41:0] a_hex;
  logic        b_load, b_blz;
  logic [3:0]  b_value;
  logic [0:0]  b_mask;
  logic [6:0]  b_hex;
`ifdef HEX_BANK_SCAN_EN
  logic [6:0]  a_seg;
  logic [5:0]  a_an;
`endif

  int tests = 0;
  int fails = 0;

  logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  hex_display_bank #(.DIGITS(6), .BLINK_DIV(4), .SCAN_DIV(2)) u_dut_a (
    .clk        (clk),
    .reset      (reset),
    .load       (a_load),
    .value      (a_value),
    .blank_lz   (a_blz),
    .blink_mask (a_mask),
`ifdef HEX_BANK_SCAN_EN
    .seg        (a_seg),
    .an         (a_an),
`endif
    .hex        (a_hex)
  );

  hex_display_bank #(.DIGITS(1), .BLINK_DIV(2), .SCAN_DIV(1)) u_dut_b (
    .clk        (clk),
    .reset      (reset),
    .load       (b_load),
    .value      (b_value),
    .blank_lz   (b_blz),
    .blink_mask (b_mask),
`ifdef HEX_BANK_SCAN_EN
    .seg        (),
    .an         (),
`endif
    .hex        (b_hex)
  );

  task automatic check(input string tag, input logic [41:0] obs, input logic [41:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0]  d0;
    logic [23:0] sv;
    logic [5:0]  e_an;
    int          idx;

    reset = 1'b1; a_load = 1'b0; a_value = '0; a_blz = 1'b0; a_mask = '0;
    b_load = 1'b0; b_value = '0; b_blz = 1'b0; b_mask = '0;
    tick; tick;
    check("reset_hex", a_hex, {6{7'h7F}});

    reset = 1'b0; a_load = 1'b1; a_value = 24'h0123AF;
    tick;
    check("first_edge_zero", a_hex, {6{7'h40}});
    a_load = 1'b0;
    tick;
    check("decode_0123AF", a_hex, {7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h0E});

    a_value = 24'h000090; a_load = 1'b1; a_blz = 1'b1;
    tick;
    a_load = 1'b0;
    tick;
    check("lz_000090", a_hex, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h10, 7'h40});
    a_blz = 1'b0;
    tick;
    check("lz_live_off", a_hex, {7'h40, 7'h40, 7'h40, 7'h40, 7'h10, 7'h40});
    a_value = 24'h0; a_load = 1'b1; a_blz = 1'b1;
    tick;
    a_load = 1'b0;
    tick;
    check("lz_zero", a_hex, {{5{7'h7F}}, 7'h40});

    // Reset wins over a simultaneous load; then blink from a known phase.
    reset = 1'b1; a_load = 1'b1; a_value = 24'h000005; a_blz = 1'b0;
    tick;
    check("midrun_reset", a_hex, {6{7'h7F}});
    reset = 1'b0; a_mask = 6'b000001;
    tick;
    check("post_reset_zero", a_hex, {6{7'h40}});
    a_load = 1'b0;
    for (int k = 2; k <= 16; k++) begin
      tick;
      if ((((k - 1) / 4) % 2) == 1) d0 = 7'h7F;
      else if (k >= 11)             d0 = 7'h78;
      else                          d0 = 7'h12;
      check($sformatf("blink_k%0d", k), a_hex, {{5{7'h40}}, d0});
      if (k == 9) begin
        a_load = 1'b1; a_value = 24'h000007;
      end else if (k == 10) begin
        a_load = 1'b0;
      end
    end
    a_mask = '0;

`ifdef HEX_BANK_SCAN_EN
    reset = 1'b1;
    tick;
    check("scan_reset_seg", {35'd0, a_seg}, {35'd0, 7'h7F});
    check("scan_reset_an", {36'd0, a_an}, {36'd0, 6'h3F});
    reset = 1'b0; a_load = 1'b1; a_value = 24'h123456; a_blz = 1'b0;
    tick;
    a_load = 1'b0;
    check("scan_first_an", {36'd0, a_an}, {36'd0, 6'h3E});
    check("scan_first_seg", {35'd0, a_seg}, {35'd0, 7'h40});
    sv = 24'h123456;
    for (int k = 2; k <= 14; k++) begin
      tick;
      idx  = ((k - 1) / 2) % 6;
      e_an = ~(6'd1 << idx);
      check($sformatf("scan_an_k%0d", k), {36'd0, a_an}, {36'd0, e_an});
      check($sformatf("scan_seg_k%0d", k), {35'd0, a_seg}, {35'd0, dec[sv[4*idx +: 4]]});
    end
    check("scan_hex_driven", a_hex, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
`endif

    reset = 1'b1;
    tick;
    check("b_reset", {35'd0, b_hex}, {35'd0, 7'h7F});
    reset = 1'b0; b_load = 1'b1; b_value = 4'hF; b_blz = 1'b1; b_mask = 1'b1;
    tick;
    check("b_first_edge", {35'd0, b_hex}, {35'd0, 7'h40});
    b_load = 1'b0;
    for (int k = 2; k <= 7; k++) begin
      tick;
      d0 = ((((k - 1) / 2) % 2) == 1) ? 7'h7F : 7'h0E;
      check($sformatf("b_blink_k%0d", k), {35'd0, b_hex}, {35'd0, d0});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
